call_scheduler: RTL



---
 rtl/call_scheduler.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/call_scheduler.sv
// Purpose : debounces the floor call buttons, latches pending calls and issues
//           one held one-hot request at a time to the elevator controller (SCAN order).
// Latency : button -> pending is 2 + DEB_CYCLES + 1 cycles; pending -> req is 2 cycles from idle.
// Backpres: a new request is issued only while busy=0; req is held until the door opens at that floor.
//
// Ports   : clk, reset_n (async active-low), btn[NUM_FLOORS] raw buttons,
//           andar_atual current floor, door_open, busy, req one-hot request,
//           pending latched calls, dir_up sweep direction (1 = up).
// Option  : define FIRE_RECALL_EN to add the fire_recall input (forces recall to floor 0).
module call_scheduler #(
    parameter int NUM_FLOORS = 5,
    parameter int DEB_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [2:0]            andar_atual,
    input  logic                  door_open,
    input  logic                  busy,
`ifdef FIRE_RECALL_EN
    input  logic                  fire_recall,
`endif
    output logic [NUM_FLOORS-1:0] req,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] SERVE = 2'd2;
    localparam int         SW    = 3;
    localparam logic [3:0] CNT_LAST = 4'(DEB_CYCLES - 1);

    logic [1:0]            state;
    logic [SW-1:0]         sel;
    logic [NUM_FLOORS-1:0] sync1, sync2, deb, deb_d;
    logic [3:0]            cnt [NUM_FLOORS];

    logic [NUM_FLOORS-1:0] rise, set_vec, clr_vec, sel_onehot, pending_n;
    logic [SW-1:0]         pos, up_sel, dn_sel, next_sel;
    logic                  up_found, dn_found, here, next_dir, serve_hit;

`ifdef FIRE_RECALL_EN
    logic recall_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) recall_d <= 1'b0;
        else          recall_d <= fire_recall;
    end
`endif

    // Input path: 2-flop synchroniser, then a per-bit run-length counter that
    // only moves the debounced level after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < NUM_FLOORS; i++) cnt[i] <= 4'd0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= 4'd0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= 4'd0;
                end else begin
                    cnt[i] <= cnt[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        rise = deb & ~deb_d;

        // Out-of-range positions are treated as floor 0 for selection.
        pos = (int'(andar_atual) < NUM_FLOORS) ? andar_atual : '0;

        here     = 1'b0;
        up_found = 1'b0;
        dn_found = 1'b0;
        up_sel   = '0;
        dn_sel   = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (pending[f] && pos == SW'(f)) here = 1'b1;
        end
        // Scan from the top down so the last hit is the nearest floor above.
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (pending[f] && f > int'(pos)) begin
                up_found = 1'b1;
                up_sel   = SW'(f);
            end
        end
        // Scan from the bottom up so the last hit is the nearest floor below.
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (pending[f] && f < int'(pos)) begin
                dn_found = 1'b1;
                dn_sel   = SW'(f);
            end
        end

        next_sel = pos;
        next_dir = dir_up;
        if (!here) begin
            if (dir_up) begin
                if (up_found) begin
                    next_sel = up_sel;
                end else begin
                    next_dir = 1'b0;
                    next_sel = dn_sel;
                end
            end else begin
                if (dn_found) begin
                    next_sel = dn_sel;
                end else begin
                    next_dir = 1'b1;
                    next_sel = up_sel;
                end
            end
        end

        // Service completes only when the door opens at the requested floor.
        serve_hit = (state == SERVE) && door_open && (andar_atual == sel);
        for (int f = 0; f < NUM_FLOORS; f++) begin
            sel_onehot[f] = (sel == SW'(f));
            clr_vec[f]    = serve_hit && (sel == SW'(f));
        end

        set_vec = rise;
`ifdef FIRE_RECALL_EN
        // Presses during recall (and its release cycle) are dropped.
        if (fire_recall || recall_d) set_vec = '0;
`endif
        // Clear has priority over a simultaneous set of the same floor.
        pending_n = (pending | set_vec) & ~clr_vec;
`ifdef FIRE_RECALL_EN
        if (fire_recall) pending_n = '0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pending <= '0;
        else          pending <= pending_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            sel    <= '0;
            req    <= '0;
            dir_up <= 1'b1;
        end else begin
`ifdef FIRE_RECALL_EN
            if (fire_recall) begin
                state  <= SERVE;
                sel    <= '0;
                req    <= NUM_FLOORS'(1);
                dir_up <= 1'b0;
            end else if (recall_d) begin
                state <= IDLE;
                req   <= '0;
            end else
`endif
            begin
                case (state)
                    IDLE: begin
                        req <= '0;
                        if (pending != '0 && !busy) begin
                            sel    <= next_sel;
                            dir_up <= next_dir;
                            state  <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        req   <= sel_onehot;
                        state <= SERVE;
                    end
                    SERVE: begin
                        if (serve_hit) begin
                            req   <= '0;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        req   <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
